// File: rtl/ketchup_pkg.sv
// rtl/ketchup_pkg.sv - shared types and constants for the Ketchup input path
package ketchup_pkg;

    localparam int KETCHUP_DATA_WIDTH = 32;

    localparam logic [1:0] CONTROL = 2'd0;
    localparam logic [1:0] STATUS  = 2'd1;
    localparam logic [1:0] INPUT   = 2'd2;
    localparam logic [1:0] COMMAND = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        GAP    = 2'd2,
        CLOSED = 2'd3
    } ketchup_state_e;

    typedef struct packed {
        logic                          last;
        logic [1:0]                    bytes;
        logic [KETCHUP_DATA_WIDTH-1:0] data;
    } ketchup_entry_t;

endpackage

// File: rtl/ketchup_sync_fifo.sv
// rtl/ketchup_sync_fifo.sv - single-clock FIFO with synchronous clear and occupancy level
module ketchup_sync_fifo #(
    parameter int WIDTH     = 35,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [PTR_WIDTH:0]   level_o
);

    localparam logic [PTR_WIDTH:0] LEVEL_FULL = (PTR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0]   level_q, level_d;
    logic                 do_push, do_pop;

    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Full/empty gating uses the registered level only, so a pop never frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (!do_push && do_pop) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ketchup_input_fifo.sv
// rtl/ketchup_input_fifo.sv - buffered word feeder from the register slave into the keccak core
module ketchup_input_fifo
    import ketchup_pkg::*;
#(
    parameter int DATA_WIDTH = KETCHUP_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic [1:0]            wr_bytes,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] core_in,
    output logic                  core_in_ready,
    output logic                  core_is_last,
    output logic [1:0]            core_byte_num,
    input  logic                  core_buffer_full,
    output logic [PTR_WIDTH:0]    level,
    output logic                  overflow,
    output logic                  msg_closed
);

    ketchup_state_e        state_q;
    logic                  lastq_q;
    logic                  overflow_q;
    logic                  msg_closed_q;
    logic                  core_in_ready_q;
    logic                  core_is_last_q;
    logic [1:0]            core_byte_num_q;
    logic [DATA_WIDTH-1:0] core_in_q;

    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    ketchup_entry_t        wr_entry, head;

    assign wr_ready = !fifo_full && !msg_closed_q && !lastq_q;
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = (state_q == ISSUE) && !flush;

    always_comb begin
        wr_entry       = '0;
        wr_entry.last  = wr_last;
        wr_entry.bytes = wr_last ? wr_bytes : 2'd0;
        wr_entry.data  = wr_data;
    end

    ketchup_sync_fifo #(
        .WIDTH     ($bits(ketchup_entry_t)),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .clr_i   (flush),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            overflow_q <= 1'b0;
            lastq_q    <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
            lastq_q    <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) overflow_q <= 1'b1;
            if (push && wr_last)       lastq_q    <= 1'b1;
        end
    end

    // GAP gives the core one cycle to raise a registered buffer_full before the next IDLE check.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q         <= IDLE;
            msg_closed_q    <= 1'b0;
            core_in_ready_q <= 1'b0;
            core_is_last_q  <= 1'b0;
            core_byte_num_q <= 2'd0;
            core_in_q       <= '0;
        end else if (flush) begin
            state_q         <= IDLE;
            msg_closed_q    <= 1'b0;
            core_in_ready_q <= 1'b0;
            core_is_last_q  <= 1'b0;
            core_byte_num_q <= 2'd0;
        end else begin
            core_in_ready_q <= 1'b0;
            core_is_last_q  <= 1'b0;
            core_byte_num_q <= 2'd0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !core_buffer_full) state_q <= ISSUE;
                end
                ISSUE: begin
                    core_in_ready_q <= 1'b1;
                    core_in_q       <= head.data;
                    core_is_last_q  <= head.last;
                    core_byte_num_q <= head.bytes;
                    if (head.last) begin
                        state_q      <= CLOSED;
                        msg_closed_q <= 1'b1;
                    end else begin
                        state_q <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                CLOSED:  state_q <= CLOSED;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_in       = core_in_q;
    assign core_in_ready = core_in_ready_q;
    assign core_is_last  = core_is_last_q;
    assign core_byte_num = core_byte_num_q;
    assign overflow      = overflow_q;
    assign msg_closed    = msg_closed_q;

endmodule

// File: tb/tb_ketchup_input_fifo.sv
// tb/tb_ketchup_input_fifo.sv - directed scoreboard bench for ketchup_input_fifo
module tb_ketchup_input_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [1:0]  wr_bytes = '0;
    logic        core_buffer_full = 1'b0;
    logic        wr_ready;
    logic [31:0] core_in;
    logic        core_in_ready;
    logic        core_is_last;
    logic [1:0]  core_byte_num;
    logic [4:0]  level;
    logic        overflow;
    logic        msg_closed;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bytes;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    bit   spacing_en = 1'b0;

    ketchup_input_fifo dut (
        .S_AXI_ACLK       (clk),
        .S_AXI_ARESETN    (rst_n),
        .flush            (flush),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .wr_bytes         (wr_bytes),
        .wr_ready         (wr_ready),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .level            (level),
        .overflow         (overflow),
        .msg_closed       (msg_closed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every issued word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && core_in_ready) begin
            strobes++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {32'd0, core_in}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("core_in", {32'd0, core_in}, {32'd0, mon_e.data});
                chk("core_is_last", {63'd0, core_is_last}, {63'd0, mon_e.last});
                chk("core_byte_num", {62'd0, core_byte_num}, {62'd0, mon_e.bytes});
            end
            if (spacing_en && last_cyc >= 0)
                chk("strobe_spacing", 64'(cyc - last_cyc), 64'd3);
            last_cyc = cyc;
        end else if (rst_n) begin
            chk("idle_qualifiers", {61'd0, core_is_last, core_byte_num}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic l, input logic [1:0] b);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        wr_bytes = b;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_bytes = 2'd0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l, input logic [1:0] b);
        exp_t e;
        e.data  = d;
        e.last  = l;
        e.bytes = b;
        sb.push_back(e);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int s0;
        int n;

        // Reset and idle
        repeat (3) tick();
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_level", {59'd0, level}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("idle_level", {59'd0, level}, 64'd0);
        chk("idle_strobe", {63'd0, core_in_ready}, 64'd0);
        chk("idle_overflow", {63'd0, overflow}, 64'd0);
        chk("idle_msg_closed", {63'd0, msg_closed}, 64'd0);

        // Single last word and latency
        push_exp(32'hDEAD_BEEF, 1'b1, 2'd2);
        wr(32'hDEAD_BEEF, 1'b1, 2'd2);
        chk("lat_k", {63'd0, core_in_ready}, 64'd0);
        chk("lat_k_level", {59'd0, level}, 64'd1);
        chk("lastq_wr_ready", {63'd0, wr_ready}, 64'd0);
        tick();
        chk("lat_k1", {63'd0, core_in_ready}, 64'd0);
        tick();
        chk("lat_k2", {63'd0, core_in_ready}, 64'd1);
        tick();
        chk("closed_msg_closed", {63'd0, msg_closed}, 64'd1);
        chk("closed_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("closed_level", {59'd0, level}, 64'd0);
        wr(32'h0000_1234, 1'b0, 2'd0);
        chk("closed_overflow", {63'd0, overflow}, 64'd1);
        do_flush();
        chk("flush_overflow", {63'd0, overflow}, 64'd0);
        chk("flush_msg_closed", {63'd0, msg_closed}, 64'd0);
        chk("flush_wr_ready", {63'd0, wr_ready}, 64'd1);

        // Fill to full under backpressure, then overflow
        core_buffer_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_exp(32'(i), 1'b0, 2'd0);
            wr(32'(i), 1'b0, 2'd3);
        end
        chk("full_level", {59'd0, level}, 64'd16);
        chk("full_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("full_no_overflow", {63'd0, overflow}, 64'd0);
        wr(32'h0000_0099, 1'b0, 2'd0);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        chk("ovf_level", {59'd0, level}, 64'd16);
        tick();
        chk("bp_hold_level", {59'd0, level}, 64'd16);

        // Backpressure release: 16 strobes spaced 3 cycles
        s0 = strobes;
        last_cyc = -1;
        spacing_en = 1'b1;
        core_buffer_full = 1'b0;
        wait_drain(100);
        spacing_en = 1'b0;
        chk("release_strobes", 64'(strobes - s0), 64'd16);
        chk("release_level", {59'd0, level}, 64'd0);

        // Pointer wrap with continuous draining
        do_flush();
        s0 = strobes;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (!wr_ready && n < 20) begin
                tick();
                n++;
            end
            chk("wrap_wr_ready", {63'd0, wr_ready}, 64'd1);
            push_exp(32'h100 + 32'(i), 1'b0, 2'd0);
            wr(32'h100 + 32'(i), 1'b0, 2'd0);
        end
        wait_drain(400);
        repeat (3) tick();
        chk("wrap_strobes", 64'(strobes - s0), 64'd40);
        chk("wrap_overflow", {63'd0, overflow}, 64'd0);
        chk("wrap_level", {59'd0, level}, 64'd0);

        // Flush mid-stream together with a write
        core_buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) wr(32'h200 + 32'(i), 1'b0, 2'd0);
        chk("pre_flush_level", {59'd0, level}, 64'd5);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h0000_0BAD;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("mid_flush_level", {59'd0, level}, 64'd0);
        chk("mid_flush_overflow", {63'd0, overflow}, 64'd0);
        chk("mid_flush_msg_closed", {63'd0, msg_closed}, 64'd0);
        chk("mid_flush_wr_ready", {63'd0, wr_ready}, 64'd1);
        s0 = strobes;
        core_buffer_full = 1'b0;
        repeat (8) tick();
        chk("mid_flush_no_strobe", 64'(strobes - s0), 64'd0);
        push_exp(32'hCAFE_0001, 1'b1, 2'd3);
        wr(32'hCAFE_0001, 1'b1, 2'd3);
        wait_drain(20);
        tick();
        chk("post_flush_closed", {63'd0, msg_closed}, 64'd1);

        // Reset mid-operation discards queued contents
        do_flush();
        core_buffer_full = 1'b1;
        wr(32'h0000_0300, 1'b0, 2'd0);
        wr(32'h0000_0301, 1'b0, 2'd0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_level", {59'd0, level}, 64'd0);
        chk("async_rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        core_buffer_full = 1'b0;
        s0 = strobes;
        repeat (6) tick();
        chk("post_rst_no_strobe", 64'(strobes - s0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
